// File: rtl/flit_injector_pkg.sv
// Shared router constants for the injection port: op encoding, field layout of the
// port-0 staging word, injector FSM states and the flit packing helper.
package flit_injector_pkg;

  localparam int OP_SIZE         = 3;
  localparam int IN_CYCLE_SIZE   = 16;
  localparam int MAXVC           = 4;
  localparam int VC_BIT_SIZE     = 2;
  localparam int DST_W           = 8;
  localparam int BUFFER_BIT_SIZE = 32;

  // Staging word layout: full | vc | timestamp | dst | tail | head, rest zero
  localparam int BUFFER_FULL       = 0;
  localparam int BUFFER_VC         = 1;
  localparam int BUFFER_TIME_STAMP = 3;
  localparam int FLIT_DST          = 19;
  localparam int FLIT_TAIL         = 27;
  localparam int FLIT_HEAD         = 28;

  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP           = 3'd0,
    OP_PHASE0        = 3'd1,
    OP_PHASE1        = 3'd2,
    OP_LOAD_STAGING  = 3'd3
  } router_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_e;

  function automatic logic [BUFFER_BIT_SIZE-1:0] pack_flit(
    input logic [VC_BIT_SIZE-1:0]   vc,
    input logic [IN_CYCLE_SIZE-1:0] ts,
    input logic [DST_W-1:0]         dst,
    input logic                     head,
    input logic                     tail
  );
    logic [BUFFER_BIT_SIZE-1:0] w;
    w = {BUFFER_BIT_SIZE{1'b0}};
    w[BUFFER_FULL]                           = 1'b1;
    w[BUFFER_VC +: VC_BIT_SIZE]              = vc;
    w[BUFFER_TIME_STAMP +: IN_CYCLE_SIZE]    = ts;
    w[FLIT_DST +: DST_W]                     = dst;
    w[FLIT_TAIL]                             = tail;
    w[FLIT_HEAD]                             = head;
    return w;
  endfunction

endpackage

// File: rtl/flit_injector_desc_fifo.sv
// Synchronous descriptor FIFO with asynchronous active-low reset.
// Pointers wrap naturally; count is one bit wider to distinguish full from empty.
module desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Injection-port traffic source: queues packet descriptors and segments each packet
// into flits on the router's port-0 staging slice, one per LoadStaging op.
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int LEN_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OP_SIZE-1:0]         op,
  input  logic [IN_CYCLE_SIZE-1:0]   in_cycle,
  input  logic [MAXVC-1:0]           can_inject,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [DST_W-1:0]           desc_dst,
  input  logic [VC_BIT_SIZE-1:0]     desc_vc,
  input  logic [LEN_W-1:0]           desc_len,
  output logic [BUFFER_BIT_SIZE-1:0] out_staging,
  output logic                       idle,
  output logic [31:0]                flits_sent
);

  localparam int DESC_W = DST_W + VC_BIT_SIZE + LEN_W;
  localparam int CNT_W  = $clog2(QDEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  inj_state_e             state_r;
  inj_state_e             state_nxt_s;
  logic [DST_W-1:0]       cur_dst_r;
  logic [VC_BIT_SIZE-1:0] cur_vc_r;
  logic [LEN_W-1:0]       remaining_r;
  logic                   first_r;
  logic [31:0]            flits_sent_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [CNT_W-1:0]       count_s;
  logic [DESC_W-1:0]      head_desc_s;
  logic [LEN_W-1:0]       hd_len_s;
  logic [VC_BIT_SIZE-1:0] hd_vc_s;
  logic [DST_W-1:0]       hd_dst_s;
  logic [LEN_W-1:0]       load_len_s;
  logic                   emit_s;
  logic                   tail_s;

  desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (QDEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({desc_dst, desc_vc, desc_len}),
    .rdata (head_desc_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign push_s     = desc_valid && !full_s;
  assign desc_ready = !full_s;
  assign idle       = (state_r == ST_IDLE) && (count_s == {CNT_W{1'b0}});
  assign flits_sent = flits_sent_r;
  assign hd_len_s   = head_desc_s[LEN_W-1:0];
  assign hd_vc_s    = head_desc_s[LEN_W +: VC_BIT_SIZE];
  assign hd_dst_s   = head_desc_s[LEN_W+VC_BIT_SIZE +: DST_W];

  // A zero-length descriptor still carries one flit
  always_comb begin
    load_len_s = hd_len_s;
    if (hd_len_s == {LEN_W{1'b0}}) begin
      load_len_s = LEN_ONE;
    end else begin
      load_len_s = hd_len_s;
    end
  end

  // Next-state, pop and emit decisions; a tail with work queued reloads without a bubble
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    emit_s      = 1'b0;
    tail_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        emit_s = (op == OP_LOAD_STAGING) && can_inject[cur_vc_r];
        tail_s = emit_s && (remaining_r == LEN_ONE);
        if (tail_s) begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_SEND;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and current-packet registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cur_dst_r    <= {DST_W{1'b0}};
      cur_vc_r     <= {VC_BIT_SIZE{1'b0}};
      remaining_r  <= {LEN_W{1'b0}};
      first_r      <= 1'b0;
      flits_sent_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        cur_dst_r   <= hd_dst_s;
        cur_vc_r    <= hd_vc_s;
        remaining_r <= load_len_s;
        first_r     <= 1'b1;
      end else if (emit_s) begin
        remaining_r <= remaining_r - LEN_ONE;
        first_r     <= 1'b0;
      end
      if (emit_s) begin
        flits_sent_r <= flits_sent_r + 32'd1;
      end
    end
  end

  // Staging word is only non-zero in the cycle a flit is actually emitted
  always_comb begin
    out_staging = {BUFFER_BIT_SIZE{1'b0}};
    if (emit_s) begin
      out_staging = pack_flit(cur_vc_r, in_cycle, cur_dst_r, first_r,
                              remaining_r == LEN_ONE);
    end else begin
      out_staging = {BUFFER_BIT_SIZE{1'b0}};
    end
  end

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: a packet-level queue model checked every
// negedge, plus hand-computed literal expectations at key points.
module tb_flit_injector;
  import flit_injector_pkg::*;

  localparam int QD = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic [15:0] in_cycle;
  logic [3:0]  can_inject;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_dst;
  logic [1:0]  desc_vc;
  logic [3:0]  desc_len;
  logic [31:0] out_staging;
  logic        idle;
  logic [31:0] flits_sent;

  typedef struct { int dst; int vc; int len; } desc_t;

  desc_t       mq[$];
  bit          m_busy;
  int          m_dst, m_vc, m_len, m_idx;
  logic [31:0] m_sent;

  int          n_checks = 0;
  int          n_fail   = 0;

  bit          lit_en;
  int          lit_sel;
  logic [31:0] lit_exp;
  string       lit_name;

  flit_injector #(.QDEPTH(QD), .LEN_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .in_cycle    (in_cycle),
    .can_inject  (can_inject),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_dst    (desc_dst),
    .desc_vc     (desc_vc),
    .desc_len    (desc_len),
    .out_staging (out_staging),
    .idle        (idle),
    .flits_sent  (flits_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(int vc, int dst, logic [15:0] ts, bit head, bit tail);
    logic [31:0] w;
    w = 32'd1 | (32'(vc) << 1) | (32'(ts) << 3) | (32'(dst) << 19)
        | (32'(tail) << 27) | (32'(head) << 28);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_busy = 1'b0;
    m_idx  = 0;
    m_len  = 0;
    m_sent = 32'd0;
  endtask

  // Packet-level behaviour at a clock edge: emit, then refill the slot, then accept
  task automatic model_step();
    bit    rdy;
    desc_t d;
    rdy = (mq.size() != QD);
    if (m_busy && op == OP_LOAD_STAGING && can_inject[m_vc]) begin
      m_idx  = m_idx + 1;
      m_sent = m_sent + 32'd1;
      if (m_idx == m_len) m_busy = 1'b0;
    end
    if (!m_busy && mq.size() > 0) begin
      d      = mq.pop_front();
      m_busy = 1'b1;
      m_dst  = d.dst;
      m_vc   = d.vc;
      m_len  = (d.len == 0) ? 1 : d.len;
      m_idx  = 0;
    end
    if (desc_valid && rdy) begin
      d.dst = int'(desc_dst);
      d.vc  = int'(desc_vc);
      d.len = int'(desc_len);
      mq.push_back(d);
    end
  endtask

  // Monitor: compare at negedge, advance the model at posedge
  initial begin
    logic [31:0] exp_out;
    logic [31:0] act;
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      exp_out = 32'd0;
      if (m_busy && op == OP_LOAD_STAGING && can_inject[m_vc])
        exp_out = mk(m_vc, m_dst, in_cycle, m_idx == 0, m_idx == m_len - 1);
      chk("out_staging", out_staging, exp_out);
      chk("desc_ready", {31'd0, desc_ready}, (mq.size() != QD) ? 32'd1 : 32'd0);
      chk("idle", {31'd0, idle}, (!m_busy && mq.size() == 0) ? 32'd1 : 32'd0);
      chk("flits_sent", flits_sent, m_sent);
      if (lit_en) begin
        case (lit_sel)
          0:       act = out_staging;
          1:       act = {31'd0, idle};
          2:       act = flits_sent;
          default: act = {31'd0, desc_ready};
        endcase
        chk(lit_name, act, lit_exp);
      end
      @(posedge clk);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  task automatic expect_lit(input int sel, input logic [31:0] exp, input string nm);
    lit_sel  = sel;
    lit_exp  = exp;
    lit_name = nm;
    lit_en   = 1'b1;
    @(negedge clk);
    #1;
    lit_en   = 1'b0;
  endtask

  task automatic tick(input logic [2:0] o);
    op = o;
    @(posedge clk);
    #1;
    in_cycle = in_cycle + 16'd1;
  endtask

  task automatic gap3();
    tick(OP_NOP);
    tick(OP_PHASE0);
    tick(OP_PHASE1);
  endtask

  task automatic push(input logic [7:0] dst, input logic [1:0] vc, input logic [3:0] len);
    desc_dst   = dst;
    desc_vc    = vc;
    desc_len   = len;
    desc_valid = 1'b1;
    tick(OP_NOP);
    desc_valid = 1'b0;
  endtask

  task automatic lit_flit(input logic [15:0] ts, input logic [31:0] exp, input string nm);
    op       = OP_LOAD_STAGING;
    in_cycle = ts;
    expect_lit(0, exp, nm);
    @(posedge clk);
    #1;
    in_cycle = in_cycle + 16'd1;
    op       = OP_NOP;
  endtask

  initial begin
    rst_n = 1'b0; op = OP_NOP; in_cycle = 16'd0; can_inject = 4'b1111;
    desc_valid = 1'b0; desc_dst = 8'd0; desc_vc = 2'd0; desc_len = 4'd0;
    lit_en = 1'b0; lit_sel = 0; lit_exp = 32'd0; lit_name = "";

    expect_lit(1, 32'd1, "reset_idle");
    expect_lit(3, 32'd1, "reset_ready");
    expect_lit(0, 32'd0, "reset_out");
    expect_lit(2, 32'd0, "reset_flits");
    rst_n = 1'b1;
    tick(OP_NOP);

    // Single 3-flit packet, ops other than LoadStaging leave it untouched
    push(8'd12, 2'd1, 4'd3);
    tick(OP_NOP);
    gap3();
    lit_flit(16'h0100, 32'h10600803, "t1_head");
    gap3();
    tick(OP_LOAD_STAGING);
    gap3();
    lit_flit(16'h0200, 32'h08601003, "t1_tail");
    expect_lit(1, 32'd1, "t1_idle");
    expect_lit(2, 32'd3, "t1_flits");

    // Zero-length descriptor becomes a single head+tail flit
    push(8'd5, 2'd2, 4'd0);
    tick(OP_NOP);
    lit_flit(16'h0300, 32'h18281805, "t2_single");
    expect_lit(1, 32'd1, "t2_idle");
    expect_lit(2, 32'd4, "t2_flits");

    // Stall on vc1 for five LoadStaging ops, other VCs stay open
    push(8'd7, 2'd1, 4'd4);
    tick(OP_NOP);
    tick(OP_LOAD_STAGING);
    can_inject = 4'b1101;
    op = OP_LOAD_STAGING;
    expect_lit(0, 32'd0, "t3_stall_out");
    tick(OP_LOAD_STAGING);
    for (int i = 0; i < 4; i++) tick(OP_LOAD_STAGING);
    can_inject = 4'b1111;
    lit_flit(16'h0400, 32'h00382003, "t3_resume");
    tick(OP_LOAD_STAGING);
    tick(OP_LOAD_STAGING);
    expect_lit(1, 32'd1, "t3_idle");
    expect_lit(2, 32'd8, "t3_flits");

    // The first descriptor moves straight into the packet slot, four more fill the FIFO
    push(8'd1, 2'd0, 4'd2);
    push(8'd2, 2'd3, 4'd1);
    push(8'd3, 2'd2, 4'd2);
    push(8'd4, 2'd1, 4'd1);
    push(8'd5, 2'd0, 4'd1);
    desc_dst = 8'd6; desc_vc = 2'd1; desc_len = 4'd3; desc_valid = 1'b1;
    op = OP_NOP;
    expect_lit(3, 32'd0, "t4_full_ready");
    tick(OP_NOP);
    tick(OP_NOP);
    desc_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick(OP_LOAD_STAGING);
    expect_lit(2, 32'd15, "t4_no_bubble_flits");
    expect_lit(1, 32'd1, "t4_idle");

    // Asynchronous reset in the middle of a 5-flit packet
    push(8'd9, 2'd0, 4'd5);
    tick(OP_NOP);
    tick(OP_LOAD_STAGING);
    tick(OP_LOAD_STAGING);
    op = OP_LOAD_STAGING;
    #2;
    rst_n = 1'b0;
    expect_lit(0, 32'd0, "t5_rst_out");
    expect_lit(2, 32'd0, "t5_rst_flits");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(OP_LOAD_STAGING);
    expect_lit(1, 32'd1, "t5_idle");
    expect_lit(2, 32'd0, "t5_flits");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
